// File: rtl/bank_fetch_pkg.sv
// Shared accelerator constants for the feature fetch path: bank geometry,
// word/index widths, skid depth and the fetch controller state encoding.
package bank_fetch_pkg;

  localparam int unsigned FB_N_BANK     = 8;
  localparam int unsigned FB_DEPTH      = 512;
  localparam int unsigned FB_DATA_W     = 16;
  localparam int unsigned FB_ADDR_W     = 9;
  localparam int unsigned FB_IDX_W      = 12;
  localparam int unsigned FB_SKID_DEPTH = 2;

  // Fetch controller states (legacy encoding kept for waveform compatibility)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Global feature index: bank number above the in-bank address
  function automatic logic [FB_IDX_W-1:0] fb_make_idx(
    input logic [FB_IDX_W-1:0]  bank,
    input logic [FB_ADDR_W-1:0] addr
  );
    return (bank << FB_ADDR_W) | FB_IDX_W'(addr);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry output skid buffer between the bank read pipeline and the
// feature stream. Head entry is held until popped; empty reads as zero.
module fetch_skid_fifo
  import bank_fetch_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FB_SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  // A full buffer may accept a word only when its head leaves in the same cycle
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage, no reset needed: contents are qualified by cnt
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = cnt;

endmodule

// File: rtl/bank_fetch.sv
// Bank fetch controller: walks a contiguous feature range spread over the
// banked feature RAMs, one read per cycle, and streams the words out through
// a two-entry skid buffer with index and last-word marking.
module bank_fetch
  import bank_fetch_pkg::*;
#(
  parameter int unsigned N_BANK = FB_N_BANK,
  parameter int unsigned DEPTH  = FB_DEPTH,
  parameter int unsigned DATA_W = FB_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_BANK-1:0]        enable,
  input  logic [FB_ADDR_W-1:0]     ram_start,
  input  logic [FB_ADDR_W-1:0]     ram_stop,
  output logic [N_BANK-1:0]        bank_rd,
  output logic [FB_ADDR_W-1:0]     bank_addr,
  input  logic [N_BANK*DATA_W-1:0] bank_rdata,
  output logic                     feat_valid,
  input  logic                     feat_ready,
  output logic [DATA_W-1:0]        feat_data,
  output logic [FB_IDX_W-1:0]      feat_idx,
  output logic                     feat_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int unsigned PAY_W  = 1 + FB_IDX_W + DATA_W;
  localparam logic [FB_ADDR_W-1:0] ADDR_MAX = FB_ADDR_W'(DEPTH - 1);

  logic [1:0]           state;
  logic [N_BANK-1:0]    en_q;
  logic [FB_ADDR_W-1:0] stop_q;
  logic [BANK_W-1:0]    bank_q;
  logic [FB_ADDR_W-1:0] addr_q;
  logic                 err_q;

  // Read issued last cycle; its data is on bank_rdata this cycle
  logic                 rd_pend_q;
  logic [BANK_W-1:0]    rd_bank_q;
  logic [FB_ADDR_W-1:0] rd_addr_q;
  logic                 rd_last_q;

  logic [BANK_W-1:0]    lo_bank;
  logic [BANK_W-1:0]    hi_bank;
  logic                 single_bank;
  logic                 reject;
  logic                 last_rd;
  logic                 issue;
  logic                 pop;
  logic [1:0]           occ;

  logic                 fifo_valid;
  logic [PAY_W-1:0]     fifo_data;
  logic [PAY_W-1:0]     push_data;
  logic [1:0]           fifo_count;
  logic                 head_last;

  // Lowest enabled bank of the incoming request (first bank to visit)
  always_comb begin
    lo_bank = '0;
    for (int unsigned i = 0; i < N_BANK; i++) begin
      if (enable[N_BANK-1-i]) lo_bank = BANK_W'(N_BANK - 1 - i);
    end
  end

  // Highest enabled bank of the latched request (last bank to visit)
  always_comb begin
    hi_bank = '0;
    for (int unsigned i = 0; i < N_BANK; i++) begin
      if (en_q[i]) hi_bank = BANK_W'(i);
    end
  end

  assign single_bank = ((enable & (enable - 1'b1)) == '0);
  assign reject      = (enable == '0) || (single_bank && (ram_stop < ram_start));
  assign last_rd     = (bank_q == hi_bank) && (addr_q == stop_q);

  assign pop = feat_valid && feat_ready;
  // Occupancy counts the word leaving this cycle as already gone, which keeps
  // the limit of two outstanding words while sustaining one word per cycle.
  assign occ   = fifo_count + {1'b0, rd_pend_q} - {1'b0, pop};
  assign issue = !rst && (state == ST_READ) && (occ < 2'(FB_SKID_DEPTH));

  // Controller state, range walk and read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      en_q      <= '0;
      stop_q    <= '0;
      bank_q    <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_bank_q <= '0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      err_q     <= 1'b0;
      if (issue) begin
        rd_bank_q <= bank_q;
        rd_addr_q <= addr_q;
        rd_last_q <= last_rd;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            en_q   <= enable;
            stop_q <= ram_stop;
            bank_q <= lo_bank;
            addr_q <= ram_start;
            if (reject) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            if (last_rd) begin
              state <= ST_DRAIN;
            end else if (addr_q == ADDR_MAX) begin
              addr_q <= '0;
              bank_q <= bank_q + 1'b1;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign push_data = {rd_last_q,
                      fb_make_idx(FB_IDX_W'(rd_bank_q), rd_addr_q),
                      bank_rdata[rd_bank_q*DATA_W +: DATA_W]};

  fetch_skid_fifo #(
    .W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend_q),
    .push_data(push_data),
    .pop      (pop),
    .out_valid(fifo_valid),
    .out_data (fifo_data),
    .count    (fifo_count)
  );

  assign head_last = fifo_data[PAY_W-1];

  // Outputs are forced quiet for as long as reset is held
  assign bank_rd    = issue ? (N_BANK'(1) << bank_q) : '0;
  assign bank_addr  = issue ? addr_q : '0;
  assign feat_valid = !rst && fifo_valid;
  assign feat_data  = rst ? '0 : fifo_data[DATA_W-1:0];
  assign feat_idx   = rst ? '0 : fifo_data[DATA_W +: FB_IDX_W];
  assign feat_last  = !rst && head_last;
  assign busy       = !rst && (state != ST_IDLE);
  assign done       = !rst && (state == ST_DONE);
  assign err        = !rst && err_q;

endmodule

// File: tb/tb_bank_fetch.sv
// Randomized bench for bank_fetch: a range-list reference model, a banked
// RAM model with one-cycle latency and a negedge stream monitor.
module tb_bank_fetch;

  localparam int NB = 8;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NB-1:0]     enable;
  logic [8:0]        ram_start;
  logic [8:0]        ram_stop;
  logic [NB-1:0]     bank_rd;
  logic [8:0]        bank_addr;
  logic [NB*DW-1:0]  bank_rdata;
  logic              feat_valid;
  logic              feat_ready;
  logic [DW-1:0]     feat_data;
  logic [11:0]       feat_idx;
  logic              feat_last;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  bank_fetch #(.N_BANK(NB), .DEPTH(512), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable),
    .ram_start(ram_start), .ram_stop(ram_stop),
    .bank_rd(bank_rd), .bank_addr(bank_addr), .bank_rdata(bank_rdata),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
    .feat_idx(feat_idx), .feat_last(feat_last),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct { int b; int a; bit last; } ent_t;

  logic [DW-1:0] mem [NB][512];
  ent_t exp_rd[$];
  ent_t exp_wd[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt, err_cnt, reads_out, words_taken, first_valid_cyc;
  int ready_mode = 0;
  bit tog = 1'b1;
  bit prev_stall = 1'b0;
  logic [DW-1:0] h_data;
  logic [11:0]   h_idx;
  logic          h_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: expand the request into the ordered list of (bank, addr)
  function automatic bit build(input logic [7:0] en, input int st, input int sp);
    int lo = -1;
    int hi = -1;
    int a_end;
    ent_t e;
    exp_rd.delete();
    exp_wd.delete();
    for (int i = 0; i < NB; i++) if (en[i]) begin
      if (lo < 0) lo = i;
      hi = i;
    end
    if (lo < 0) return 1'b1;
    if (lo == hi && sp < st) return 1'b1;
    for (int b = lo; b <= hi; b++) begin
      a_end = (b == hi) ? sp : 511;
      for (int a = (b == lo) ? st : 0; a <= a_end; a++) begin
        e.b = b; e.a = a; e.last = (b == hi) && (a == sp);
        exp_rd.push_back(e);
        exp_wd.push_back(e);
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Banked RAM: selected bank returns its word next cycle, others return noise
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      bank_rdata[b*DW +: DW] <= bank_rd[b] ? mem[b][bank_addr] : DW'($urandom);
  end

  // Ready pattern generator
  initial begin
    feat_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: feat_ready = 1'b1;
        1: begin feat_ready = tog; tog = !tog; end
        default: feat_ready = 1'($urandom);
      endcase
    end
  end

  // Stream monitor
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (bank_rd != '0) begin
          reads_out++;
          if (exp_rd.size() == 0) check("unexpected_rd", 64'(bank_rd), 64'(0));
          else begin
            e = exp_rd.pop_front();
            check("rd_strobe", 64'(bank_rd), 64'(1) << e.b);
            check("rd_addr", 64'(bank_addr), 64'(e.a));
          end
        end
        if (prev_stall) begin
          check("hold_valid", 64'(feat_valid), 64'(1));
          check("hold_data", 64'(feat_data), 64'(h_data));
          check("hold_idx", 64'(feat_idx), 64'(h_idx));
          check("hold_last", 64'(feat_last), 64'(h_last));
        end
        if (feat_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (feat_valid && feat_ready) begin
          words_taken++;
          if (exp_wd.size() == 0) check("unexpected_word", 64'(1), 64'(0));
          else begin
            e = exp_wd.pop_front();
            check("data", 64'(feat_data), 64'(mem[e.b][e.a]));
            check("idx", 64'(feat_idx), 64'(e.b * 512 + e.a));
            check("last", 64'(feat_last), 64'(e.last));
          end
        end
        check("outstanding_le2", 64'((reads_out - words_taken) <= 2), 64'(1));
        prev_stall = feat_valid && !feat_ready;
        h_data = feat_data;
        h_idx  = feat_idx;
        h_last = feat_last;
        if (done) done_cnt++;
        if (err)  err_cnt++;
      end
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_bank_rd"},    64'(bank_rd),    64'(0));
    check({tag, "_bank_addr"},  64'(bank_addr),  64'(0));
    check({tag, "_feat_valid"}, 64'(feat_valid), 64'(0));
    check({tag, "_feat_data"},  64'(feat_data),  64'(0));
    check({tag, "_feat_idx"},   64'(feat_idx),   64'(0));
    check({tag, "_feat_last"},  64'(feat_last),  64'(0));
    check({tag, "_busy"},       64'(busy),       64'(0));
    check({tag, "_done"},       64'(done),       64'(0));
    check({tag, "_err"},        64'(err),        64'(0));
  endtask

  task automatic clear_counts();
    done_cnt = 0; err_cnt = 0; reads_out = 0; words_taken = 0; first_valid_cyc = -1;
  endtask

  task automatic issue_start(input logic [7:0] en, input int st, input int sp, output int scyc);
    @(posedge clk); #1;
    start = 1'b1; enable = en; ram_start = 9'(st); ram_stop = 9'(sp);
    scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    enable = 8'($urandom); ram_start = 9'($urandom); ram_stop = 9'($urandom);
  endtask

  task automatic run_req(input logic [7:0] en, input int st, input int sp,
                         input int mode, input bit intrude);
    bit rej;
    int n;
    int scyc;
    rej = build(en, st, sp);
    n = exp_wd.size();
    ready_mode = mode;
    tog = 1'b1;
    clear_counts();
    issue_start(en, st, sp, scyc);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      if (intrude && i == 3) begin
        check("busy_at_restart", 64'(busy), 64'(1));
        start = 1'b1; enable = 8'hFF; ram_start = 9'd0; ram_stop = 9'd300;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", 64'(done_cnt != 0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("err_pulses", 64'(err_cnt), 64'(rej));
    check("reads_issued", 64'(reads_out), 64'(n));
    check("reads_left", 64'(exp_rd.size()), 64'(0));
    check("words_taken", 64'(words_taken), 64'(n));
    check("words_left", 64'(exp_wd.size()), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    if (!rej) check("first_valid_latency_ge2", 64'((first_valid_cyc - scyc) >= 2), 64'(1));
  endtask

  task automatic run_abort();
    bit rej;
    int scyc;
    rej = build(8'hC0, 0, 5);
    check("abort_req_accepted", 64'(rej), 64'(0));
    ready_mode = 0;
    clear_counts();
    issue_start(8'hC0, 0, 5, scyc);
    for (int i = 0; i < 100 && words_taken < 3; i++) begin
      @(posedge clk); #1;
    end
    check("abort_3_words", 64'(words_taken), 64'(3));
    rst = 1'b1;
    exp_rd.delete();
    exp_wd.delete();
    @(negedge clk);
    check_quiet("in_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    reads_out = 0; words_taken = 0;
    @(negedge clk);
    check_quiet("after_rst");
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt), 64'(0));
    check("abort_no_words", 64'(words_taken), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lo, hi, st, sp;
    logic [7:0] en;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 512; a++) mem[b][a] = DW'($urandom);
    rst = 1'b1; start = 1'b0; enable = '0; ram_start = '0; ram_stop = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    run_req(8'h04, 10, 13, 0, 1'b0);
    run_req(8'h06, 510, 1, 0, 1'b0);
    run_req(8'h01, 0, 7, 1, 1'b0);
    run_req(8'h00, 0, 0, 0, 1'b0);
    run_req(8'h08, 20, 5, 0, 1'b0);
    run_req(8'h03, 500, 2, 2, 1'b0);
    run_req(8'h05, 505, 3, 0, 1'b0);
    run_req(8'h10, 42, 42, 1, 1'b0);
    run_req(8'h01, 100, 110, 0, 1'b1);
    run_abort();
    run_req(8'hC0, 500, 3, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      lo = int'($urandom % 8);
      hi = lo + int'($urandom % 3);
      if (hi > 7) hi = 7;
      en = '0;
      en[lo] = 1'b1;
      en[hi] = 1'b1;
      for (int b = lo + 1; b < hi; b++) en[b] = 1'($urandom);
      if (lo == hi) begin
        st = int'($urandom % 512);
        if ($urandom % 6 == 0) sp = int'($urandom % 512);
        else begin
          sp = st + int'($urandom % 24);
          if (sp > 511) sp = 511;
        end
      end else begin
        st = 511 - int'($urandom % 12);
        sp = int'($urandom % 12);
      end
      if ($urandom % 10 == 0) en = '0;
      run_req(en, st, sp, int'($urandom % 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
